// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM port between a high-priority scanout reader and a
// buffered pixel writer, sequencing write strobes, bus turnaround and starvation relief.
module sram_port_arbiter #(
   parameter int ADDR_W       = 19,
   parameter int DATA_W       = 8,
   parameter int WR_DEPTH     = 4,
   parameter int WE_CYCLES    = 1,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                      MainClk,
   input  logic                      Reset,
   input  logic                      RdReq,
   input  logic [ADDR_W-1:0]         RdAddr,
   output logic                      RdAck,
   output logic [DATA_W-1:0]         RdData,
   output logic                      RdValid,
   input  logic                      WrReq,
   input  logic [ADDR_W-1:0]         WrAddr,
   input  logic [DATA_W-1:0]         WrData,
   output logic                      WrReady,
   output logic [$clog2(WR_DEPTH):0] BufLevel,
   output logic [ADDR_W-1:0]         MemAddr,
   output logic [DATA_W-1:0]         MemDataOut,
   input  logic [DATA_W-1:0]         MemDataIn,
   output logic                      MemDataOE,
   output logic                      MemWE,
   output logic                      MemOE
);
   localparam int PTR_W = $clog2(WR_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam int PC_W  = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_READ, ST_TURN, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD
   } state_t;

   state_t             state_q;
   logic [ADDR_W-1:0]  fifo_addr_q [WR_DEPTH];
   logic [DATA_W-1:0]  fifo_data_q [WR_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic [LVL_W-1:0]   level_d;
   logic               wr_ready_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic [STV_W-1:0]   starve_q;
   logic [STV_W-1:0]   starve_d;
   logic [PC_W-1:0]    pulse_cnt_q;
   logic               rd_ack_q;
   logic               rd_valid_q;
   logic [DATA_W-1:0]  rd_data_q;
   logic               mem_oe_n_q;
   logic               mem_we_n_q;
   logic               data_oe_q;

   logic               push;
   logic               pop;
   logic               buf_ne;
   logic               force_wr;
   logic               arb_point;
   logic               want_rd;
   logic               want_wr;
   logic               wr_phase;

   // Arbitration happens in IDLE, READ and WR_HOLD; TURN only finishes a read already chosen.
   always_comb begin
      buf_ne    = (level_q != '0);
      force_wr  = (starve_q == STV_W'(STARVE_LIMIT)) && buf_ne;
      arb_point = (state_q == ST_IDLE) || (state_q == ST_READ) || (state_q == ST_WR_HOLD);
      want_rd   = 1'b0;
      if (arb_point) begin
         want_rd = RdReq && !force_wr;
      end else if (state_q == ST_TURN) begin
         want_rd = RdReq;
      end
      want_wr = (arb_point || (state_q == ST_TURN)) && !want_rd && buf_ne;
      push    = WrReq && wr_ready_q;
      pop     = want_wr;
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);

      starve_d = starve_q;
      if (!buf_ne || want_wr) begin
         starve_d = '0;
      end else if (want_rd && (state_q != ST_WR_HOLD) &&
                   (starve_q != STV_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + STV_W'(1);
      end
   end

   // Write buffer storage: no reset so it maps onto RAM; the popped entry is read registered.
   always_ff @(posedge MainClk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= WrAddr;
         fifo_data_q[wr_ptr_q] <= WrData;
      end
      if (pop) begin
         wr_addr_q <= fifo_addr_q[rd_ptr_q];
         wr_data_q <= fifo_data_q[rd_ptr_q];
      end
   end

   always_ff @(posedge MainClk) begin
      if (Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         wr_ready_q <= 1'b1;
         starve_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         level_q    <= level_d;
         wr_ready_q <= (level_d != LVL_W'(WR_DEPTH));
         starve_q   <= starve_d;
      end
   end

   // Outputs are registered as the strobes for the state being entered.
   always_ff @(posedge MainClk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         rd_ack_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         mem_oe_n_q  <= 1'b1;
         mem_we_n_q  <= 1'b1;
         data_oe_q   <= 1'b0;
         pulse_cnt_q <= '0;
      end else begin
         rd_ack_q   <= 1'b0;
         mem_oe_n_q <= 1'b1;
         mem_we_n_q <= 1'b1;
         data_oe_q  <= 1'b0;
         rd_valid_q <= rd_ack_q;
         if (rd_ack_q) begin
            rd_data_q <= MemDataIn;
         end
         case (state_q)
            ST_WR_SETUP: begin
               state_q     <= ST_WR_PULSE;
               data_oe_q   <= 1'b1;
               mem_we_n_q  <= 1'b0;
               pulse_cnt_q <= PC_W'(WE_CYCLES - 1);
            end
            ST_WR_PULSE: begin
               data_oe_q <= 1'b1;
               if (pulse_cnt_q == '0) begin
                  state_q <= ST_WR_HOLD;
               end else begin
                  pulse_cnt_q <= pulse_cnt_q - PC_W'(1);
                  mem_we_n_q  <= 1'b0;
               end
            end
            default: begin
               if (want_rd && (state_q != ST_WR_HOLD)) begin
                  state_q    <= ST_READ;
                  rd_ack_q   <= 1'b1;
                  mem_oe_n_q <= 1'b0;
               end else if (want_rd) begin
                  state_q <= ST_TURN;
               end else if (want_wr) begin
                  state_q   <= ST_WR_SETUP;
                  data_oe_q <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign wr_phase = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) ||
                     (state_q == ST_WR_HOLD);

   // The read address is taken live in the RdAck cycle so a registered requestor
   // can advance it every clock.
   assign MemAddr    = (state_q == ST_READ) ? RdAddr : (wr_phase ? wr_addr_q : '0);
   assign MemDataOut = wr_phase ? wr_data_q : '0;
   assign MemDataOE  = data_oe_q;
   assign MemWE      = mem_we_n_q;
   assign MemOE      = mem_oe_n_q;
   assign RdAck      = rd_ack_q;
   assign RdValid    = rd_valid_q;
   assign RdData     = rd_data_q;
   assign WrReady    = wr_ready_q;
   assign BufLevel   = level_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, single write, reads, starvation,
// read priority, push+pop at level 2 and reset during a write pulse.
module tb_sram_port_arbiter;
   logic          clk;
   logic          srst;
   logic          rd_req;
   logic [18:0]   rd_addr;
   logic          rd_ack;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          wr_req;
   logic [18:0]   wr_addr;
   logic [7:0]    wr_data;
   logic          wr_ready;
   logic [2:0]    buf_level;
   logic [18:0]   mem_addr;
   logic [7:0]    mem_data_out;
   logic [7:0]    mem_data_in;
   logic          mem_data_oe;
   logic          mem_we;
   logic          mem_oe;

   int            checks = 0;
   int            errors = 0;
   int            oe_viol = 0;
   int            log_base;
   int            acks_ne;
   int            prev_lvl;
   logic          found;
   logic [26:0]   wr_log [$];
   logic [7:0]    sram [256];

   sram_port_arbiter dut (
      .MainClk    (clk),
      .Reset      (srst),
      .RdReq      (rd_req),
      .RdAddr     (rd_addr),
      .RdAck      (rd_ack),
      .RdData     (rd_data),
      .RdValid    (rd_valid),
      .WrReq      (wr_req),
      .WrAddr     (wr_addr),
      .WrData     (wr_data),
      .WrReady    (wr_ready),
      .BufLevel   (buf_level),
      .MemAddr    (mem_addr),
      .MemDataOut (mem_data_out),
      .MemDataIn  (mem_data_in),
      .MemDataOE  (mem_data_oe),
      .MemWE      (mem_we),
      .MemOE      (mem_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [7:0] a);
      return a ^ 8'h5A;
   endfunction

   // SRAM model: read contents are fixed; every write strobe is logged in order.
   assign mem_data_in = (mem_oe == 1'b0) ? sram[mem_addr[7:0]] : 8'h00;

   always @(posedge clk) begin
      if (!srst && mem_we === 1'b0) begin
         wr_log.push_back({mem_addr, mem_data_out});
         $display("write strobe addr=0x%05h data=0x%02h", mem_addr, mem_data_out);
      end
      if (!srst && rd_valid === 1'b1) begin
         $display("read data 0x%02h", rd_data);
      end
   end

   always @(negedge clk) begin
      if (mem_oe === 1'b0 && mem_data_oe === 1'b1) begin
         oe_viol <= oe_viol + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i] = pat(8'(i));
      end
      sram[8'h10] = 8'hAB;

      srst = 1'b1; rd_req = 1'b0; rd_addr = '0;
      wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) tick();
      check_val("rst_we",      32'(mem_we), 32'd1);
      check_val("rst_oe",      32'(mem_oe), 32'd1);
      check_val("rst_data_oe", 32'(mem_data_oe), 32'd0);
      check_val("rst_addr",    32'(mem_addr), 32'd0);
      check_val("rst_rd_ack",  32'(rd_ack), 32'd0);
      check_val("rst_rd_vld",  32'(rd_valid), 32'd0);
      check_val("rst_rd_data", 32'(rd_data), 32'd0);
      check_val("rst_level",   32'(buf_level), 32'd0);
      check_val("rst_ready",   32'(wr_ready), 32'd1);
      srst = 1'b0;
      repeat (2) tick();

      // Single write from idle
      log_base = wr_log.size();
      wr_req = 1'b1; wr_addr = 19'h00123; wr_data = 8'h30;
      tick(); wr_req = 1'b0;
      check_val("t2_level", 32'(buf_level), 32'd1);
      tick();
      check_val("t2_setup_doe",  32'(mem_data_oe), 32'd1);
      check_val("t2_setup_we",   32'(mem_we), 32'd1);
      check_val("t2_setup_oe",   32'(mem_oe), 32'd1);
      check_val("t2_setup_addr", 32'(mem_addr), 32'h123);
      check_val("t2_setup_data", 32'(mem_data_out), 32'h30);
      tick();
      check_val("t2_pulse_we",   32'(mem_we), 32'd0);
      check_val("t2_pulse_doe",  32'(mem_data_oe), 32'd1);
      check_val("t2_pulse_addr", 32'(mem_addr), 32'h123);
      check_val("t2_pulse_data", 32'(mem_data_out), 32'h30);
      tick();
      check_val("t2_hold_we",    32'(mem_we), 32'd1);
      check_val("t2_hold_doe",   32'(mem_data_oe), 32'd1);
      check_val("t2_hold_addr",  32'(mem_addr), 32'h123);
      check_val("t2_hold_data",  32'(mem_data_out), 32'h30);
      tick();
      check_val("t2_idle_doe",   32'(mem_data_oe), 32'd0);
      check_val("t2_wr_count",   32'(wr_log.size() - log_base), 32'd1);
      check_val("t2_wr_entry",   32'(wr_log[log_base]), 32'h0001_2330);
      tick();

      // Single read, then one read per clock
      rd_req = 1'b1; rd_addr = 19'h00010;
      tick(); #1;
      check_val("t3_ack",      32'(rd_ack), 32'd1);
      check_val("t3_oe",       32'(mem_oe), 32'd0);
      check_val("t3_addr",     32'(mem_addr), 32'h10);
      check_val("t3_doe",      32'(mem_data_oe), 32'd0);
      rd_req = 1'b0;
      tick();
      check_val("t3_valid",    32'(rd_valid), 32'd1);
      check_val("t3_data",     32'(rd_data), 32'hAB);
      check_val("t3_ack_off",  32'(rd_ack), 32'd0);
      check_val("t3_oe_off",   32'(mem_oe), 32'd1);
      rd_req = 1'b1; rd_addr = 19'h00020;
      for (int i = 0; i < 4; i++) begin
         tick();
         rd_addr = 19'h00020 + 19'(i);
         #1;
         check_val("t3_burst_ack",  32'(rd_ack), 32'd1);
         check_val("t3_burst_addr", 32'(mem_addr), 32'h20 + 32'(i));
         if (i > 0) begin
            check_val("t3_burst_data", 32'(rd_data), 32'(pat(8'h20 + 8'(i - 1))));
         end
         if (i == 3) rd_req = 1'b0;
      end
      tick();
      check_val("t3_last_valid", 32'(rd_valid), 32'd1);
      check_val("t3_last_data",  32'(rd_data), 32'(pat(8'h23)));
      tick();

      // Starvation guard with reads held and a full buffer
      log_base = wr_log.size();
      rd_req = 1'b1; rd_addr = 19'h00040;
      wr_req = 1'b1; wr_addr = 19'h00080; wr_data = 8'h10;
      prev_lvl = int'(buf_level);
      acks_ne = 0;
      found = 1'b0;
      for (int k = 1; k < 60 && !found; k++) begin
         tick();
         if (k < 5) begin
            wr_req = 1'b1; wr_addr = 19'h00080 + 19'(k); wr_data = 8'h10 + 8'(k);
         end else begin
            wr_req = 1'b0;
         end
         if (k == 3) check_val("t4_ready_l3", 32'(wr_ready), 32'd1);
         if (k == 4) begin
            check_val("t4_ready_full", 32'(wr_ready), 32'd0);
            check_val("t4_level_full", 32'(buf_level), 32'd4);
         end
         if (rd_ack && prev_lvl != 0) acks_ne++;
         if (mem_data_oe) found = 1'b1;
         prev_lvl = int'(buf_level);
      end
      wr_req = 1'b0;
      check_val("t4_force_seen", 32'(found), 32'd1);
      check_val("t4_acks",       32'(acks_ne), 32'd16);
      check_val("t4_force_addr", 32'(mem_addr), 32'h80);
      check_val("t4_force_data", 32'(mem_data_out), 32'h10);
      tick();
      check_val("t4_pulse_we",   32'(mem_we), 32'd0);
      tick();
      check_val("t4_hold_we",    32'(mem_we), 32'd1);
      check_val("t4_hold_doe",   32'(mem_data_oe), 32'd1);
      tick();
      check_val("t4_turn_ack",   32'(rd_ack), 32'd0);
      check_val("t4_turn_doe",   32'(mem_data_oe), 32'd0);
      check_val("t4_turn_oe",    32'(mem_oe), 32'd1);
      tick();
      check_val("t4_read_ack",   32'(rd_ack), 32'd1);
      check_val("t4_read_oe",    32'(mem_oe), 32'd0);
      rd_req = 1'b0;
      repeat (14) tick();
      check_val("t4_drained",    32'(buf_level), 32'd0);
      check_val("t4_wr_count",   32'(wr_log.size() - log_base), 32'd4);
      check_val("t4_wr0",        32'(wr_log[log_base]),     32'h0000_8010);
      check_val("t4_wr1",        32'(wr_log[log_base + 1]), 32'h0000_8111);
      check_val("t4_wr2",        32'(wr_log[log_base + 2]), 32'h0000_8212);
      check_val("t4_wr3",        32'(wr_log[log_base + 3]), 32'h0000_8313);

      // Read and write pending together: read wins
      wr_req = 1'b1; wr_addr = 19'h00055; wr_data = 8'h05;
      tick();
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = 19'h00011;
      check_val("t5_level",     32'(buf_level), 32'd1);
      tick();
      check_val("t5_rd_first",  32'(rd_ack), 32'd1);
      check_val("t5_rd_doe",    32'(mem_data_oe), 32'd0);
      tick();
      check_val("t5_rd_second", 32'(rd_ack), 32'd1);
      rd_req = 1'b0;
      tick();
      check_val("t5_wr_doe",    32'(mem_data_oe), 32'd1);
      check_val("t5_wr_addr",   32'(mem_addr), 32'h55);
      check_val("t5_wr_noack",  32'(rd_ack), 32'd0);
      tick();
      check_val("t5_wr_pulse",  32'(mem_we), 32'd0);
      repeat (3) tick();

      // Push and pop in the same cycle at level 2
      log_base = wr_log.size();
      rd_req = 1'b1; rd_addr = 19'h00012;
      wr_req = 1'b1; wr_addr = 19'h000A1; wr_data = 8'h01;
      tick();
      wr_addr = 19'h000B2; wr_data = 8'h02;
      tick();
      check_val("t6_level_pre",  32'(buf_level), 32'd2);
      rd_req = 1'b0; wr_addr = 19'h000C3; wr_data = 8'h03;
      tick();
      wr_req = 1'b0;
      check_val("t6_level_post", 32'(buf_level), 32'd2);
      check_val("t6_head_addr",  32'(mem_addr), 32'hA1);
      repeat (14) tick();
      check_val("t6_wr_count",   32'(wr_log.size() - log_base), 32'd3);
      check_val("t6_wr0",        32'(wr_log[log_base]),     32'h0000_A101);
      check_val("t6_wr1",        32'(wr_log[log_base + 1]), 32'h0000_B202);
      check_val("t6_wr2",        32'(wr_log[log_base + 2]), 32'h0000_C303);

      // Reset during the write pulse drops the buffered write
      wr_req = 1'b1; wr_addr = 19'h000D0; wr_data = 8'h0D;
      tick();
      wr_addr = 19'h000E0; wr_data = 8'h0E;
      tick();
      wr_req = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         tick();
         if (mem_we == 1'b0) found = 1'b1;
      end
      check_val("t1_pulse_seen", 32'(found), 32'd1);
      check_val("t1_level_pre",  32'(buf_level), 32'd1);
      srst = 1'b1;
      tick();
      check_val("t1_we",         32'(mem_we), 32'd1);
      check_val("t1_doe",        32'(mem_data_oe), 32'd0);
      tick(); tick();
      check_val("t1_level",      32'(buf_level), 32'd0);
      check_val("t1_ready",      32'(wr_ready), 32'd1);
      check_val("t1_addr",       32'(mem_addr), 32'd0);
      log_base = wr_log.size();
      srst = 1'b0;
      repeat (10) tick();
      check_val("t1_lost",       32'(wr_log.size() - log_base), 32'd0);
      check_val("t1_level_post", 32'(buf_level), 32'd0);

      check_val("oe_exclusive",  32'(oe_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
